// File: rtl/priority_arbiter_n.sv
// N-way request arbiter with latched pending requests, per-line masking and a
// held grant/ack handshake; fixed-priority or descending round-robin selection.
module priority_arbiter_n #(
    parameter int unsigned N       = 8,
    parameter int unsigned W       = $clog2(N),
    parameter int unsigned RR_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         grant_ack,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] pending,
    output logic         any_pending
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e       state_q;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic [N-1:0] clr;
    logic [N-1:0] eligible;
    logic [N-1:0] shifted;
    logic [W-1:0] grant_idx_q;
    logic [W-1:0] ptr_q;
    logic [W-1:0] sel_idx;
    logic         grant_valid_q;
    logic         ack_accept;
    logic         sel_found;
    int unsigned  cand;

    assign eligible    = pending_q & ~mask;
    assign ack_accept  = grant_valid_q & grant_ack;
    assign any_pending = |eligible;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign pending     = pending_q;

    always_comb begin
        clr = '0;
        if (ack_accept) begin
            clr[grant_idx_q] = 1'b1;
        end
    end

    // Requests arriving on the ack edge win over the clear of the granted bit.
    assign pending_d = (pending_q & ~clr) | req;

    // Search descends from ptr-1 with wrap; fixed priority is the same walk
    // anchored at 0, which visits N-1 down to 0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        shifted   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (RR_MODE != 0) ? 32'(ptr_q) + N - i : N - i;
            if (cand >= N) begin
                cand = cand - N;
            end
            shifted = eligible >> cand;
            if (!sel_found && shifted[0]) begin
                sel_found = 1'b1;
                sel_idx   = W'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            ptr_q         <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        grant_idx_q   <= sel_idx;
                        grant_valid_q <= 1'b1;
                        state_q       <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ack) begin
                        grant_valid_q <= 1'b0;
                        ptr_q         <= grant_idx_q;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Scoreboard bench for priority_arbiter_n: four configurations driven together,
// checked against a behavioural model plus directed scenarios with fixed answers.
module tb_priority_arbiter_n;

    bit clk;
    always #5 clk = ~clk;

    logic            rst;
    logic [3:0][7:0] req_v;
    logic [3:0][7:0] mask_v;
    logic [3:0]      ack_v;

    logic [3:0] p0, p1;
    logic [7:0] p2, p3;
    logic [1:0] i0, i1;
    logic [2:0] i2, i3;
    logic [3:0] val_o;
    logic [3:0] anyp_o;
    logic [3:0][7:0] pend_o;
    logic [3:0][2:0] idx_o;

    always_comb begin
        pend_o = '0;
        idx_o  = '0;
        pend_o[0][3:0] = p0;
        pend_o[1][3:0] = p1;
        pend_o[2]      = p2;
        pend_o[3]      = p3;
        idx_o[0][1:0]  = i0;
        idx_o[1][1:0]  = i1;
        idx_o[2]       = i2;
        idx_o[3]       = i3;
    end

    priority_arbiter_n #(.N(4), .RR_MODE(0)) u_fp4 (
        .clk(clk), .rst(rst), .req(req_v[0][3:0]), .mask(mask_v[0][3:0]),
        .grant_ack(ack_v[0]), .grant_valid(val_o[0]), .grant_idx(i0),
        .pending(p0), .any_pending(anyp_o[0]));
    priority_arbiter_n #(.N(4), .RR_MODE(1)) u_rr4 (
        .clk(clk), .rst(rst), .req(req_v[1][3:0]), .mask(mask_v[1][3:0]),
        .grant_ack(ack_v[1]), .grant_valid(val_o[1]), .grant_idx(i1),
        .pending(p1), .any_pending(anyp_o[1]));
    priority_arbiter_n #(.N(8), .RR_MODE(0)) u_fp8 (
        .clk(clk), .rst(rst), .req(req_v[2]), .mask(mask_v[2]),
        .grant_ack(ack_v[2]), .grant_valid(val_o[2]), .grant_idx(i2),
        .pending(p2), .any_pending(anyp_o[2]));
    priority_arbiter_n #(.N(8), .RR_MODE(1)) u_rr8 (
        .clk(clk), .rst(rst), .req(req_v[3]), .mask(mask_v[3]),
        .grant_ack(ack_v[3]), .grant_valid(val_o[3]), .grant_idx(i3),
        .pending(p3), .any_pending(anyp_o[3]));

    int unsigned NN[4] = '{4, 4, 8, 8};
    bit          RR[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct packed {
        logic [3:0][7:0] pend;
        logic [3:0]      val;
        logic [3:0][2:0] idx;
        logic [3:0]      anyp;
    } snap_t;

    typedef struct packed {
        logic [1:0] d;
        logic [2:0] idx;
    } gexp_t;

    snap_t snapq[$];
    gexp_t gq[$];

    logic [7:0]  m_pend[4];
    bit          m_val[4];
    int unsigned m_idx[4];
    int unsigned m_ptr[4];
    bit          directed;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  prev_v  = '0;

    task automatic chk(string name, int d, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, d, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] nm(int d);
        return (NN[d] == 8) ? 8'hFF : 8'h0F;
    endfunction

    // Reference selection: highest index for fixed priority; for round-robin,
    // walk downward from the last acknowledged index with wrap-around.
    function automatic int unsigned pick(int d, logic [7:0] elig);
        if (!RR[d]) begin
            for (int i = int'(NN[d]) - 1; i >= 0; i--)
                if (elig[i]) return i;
        end else begin
            for (int unsigned s = 1; s <= NN[d]; s++) begin
                int unsigned c;
                c = (m_ptr[d] + NN[d] - s) % NN[d];
                if (elig[c]) return c;
            end
        end
        return 0;
    endfunction

    task automatic model_step(int d);
        logic [7:0] elig;
        logic [7:0] clr;
        logic [7:0] nxt;
        bit         acc;
        if (rst) begin
            m_pend[d] = '0;
            m_val[d]  = 1'b0;
            m_idx[d]  = 0;
            m_ptr[d]  = 0;
        end else begin
            elig = m_pend[d] & ~mask_v[d] & nm(d);
            acc  = m_val[d] && ack_v[d];
            clr  = acc ? 8'(1 << m_idx[d]) : 8'h00;
            nxt  = ((m_pend[d] & ~clr) | req_v[d]) & nm(d);
            if (m_val[d]) begin
                if (acc) begin
                    m_val[d] = 1'b0;
                    m_ptr[d] = m_idx[d];
                end
            end else if (elig != 0) begin
                m_idx[d] = pick(d, elig);
                m_val[d] = 1'b1;
                if (!directed) gq.push_back('{d: 2'(d), idx: 3'(m_idx[d])});
            end
            m_pend[d] = nxt;
        end
    endtask

    task automatic tick();
        snap_t s;
        @(posedge clk);
        for (int d = 0; d < 4; d++) begin
            model_step(d);
            s.pend[d] = m_pend[d];
            s.val[d]  = m_val[d];
            s.idx[d]  = 3'(m_idx[d]);
            s.anyp[d] = |(m_pend[d] & ~mask_v[d] & nm(d));
        end
        snapq.push_back(s);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_v  = '0;
        mask_v = '0;
        ack_v  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic exp_g(int d, int idx);
        gq.push_back('{d: 2'(d), idx: 3'(idx)});
    endtask

    task automatic ack_grant(int d);
        for (int k = 0; k < 20; k++) begin
            if (val_o[d] === 1'b1) begin
                ack_v[d] = 1'b1;
                tick();
                ack_v[d] = 1'b0;
                return;
            end
            tick();
        end
        n_tests++;
        n_fail++;
        $display("FAIL grant_timeout inst=%0d got=no_grant expected=grant t=%0t", d, $time);
    endtask

    always @(negedge clk) begin
        snap_t s;
        gexp_t g;
        if (snapq.size() != 0) begin
            s = snapq.pop_front();
            for (int d = 0; d < 4; d++) begin
                chk("pending", d, 32'(pend_o[d]), 32'(s.pend[d]));
                chk("grant_valid", d, 32'(val_o[d]), 32'(s.val[d]));
                chk("grant_idx", d, 32'(idx_o[d]), 32'(s.idx[d]));
                chk("any_pending", d, 32'(anyp_o[d]), 32'(s.anyp[d]));
            end
        end
        for (int d = 0; d < 4; d++) begin
            if (val_o[d] === 1'b1 && !prev_v[d]) begin
                if (gq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL grant_unexpected inst=%0d got=%0d expected=none", d, idx_o[d]);
                end else begin
                    g = gq.pop_front();
                    chk("grant_inst", d, 32'(d), 32'(g.d));
                    chk("grant_seq", d, 32'(idx_o[d]), 32'(g.idx));
                end
            end
            prev_v[d] = val_o[d];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        directed = 1'b1;
        rst      = 1'b1;
        req_v    = '0;
        mask_v   = '0;
        ack_v    = '0;

        // Fixed priority, two requests served high index first.
        do_reset();
        chk("rst_idx", 0, 32'(idx_o[0]), 0);
        chk("rst_valid", 0, 32'(val_o[0]), 0);
        chk("rst_pend", 0, 32'(pend_o[0]), 0);
        exp_g(0, 1);
        exp_g(0, 0);
        req_v[0] = 8'h03;
        tick();
        req_v[0] = '0;
        ack_grant(0);
        ack_grant(0);
        tick();
        chk("t028_valid", 0, 32'(val_o[0]), 0);
        chk("t028_pend", 0, 32'(pend_o[0]), 0);
        chk("t028_queue", 0, gq.size(), 0);

        // Masked bit stays pending and is served once unmasked.
        do_reset();
        exp_g(0, 0);
        exp_g(0, 3);
        mask_v[0] = 8'h08;
        req_v[0]  = 8'h09;
        tick();
        req_v[0] = '0;
        ack_grant(0);
        repeat (3) tick();
        chk("t029_valid", 0, 32'(val_o[0]), 0);
        chk("t029_pend", 0, 32'(pend_o[0]), 32'h08);
        chk("t029_anyp", 0, 32'(anyp_o[0]), 0);
        mask_v[0] = '0;
        ack_grant(0);
        tick();
        chk("t029_queue", 0, gq.size(), 0);

        // Round-robin with all requests held.
        do_reset();
        exp_g(1, 3);
        exp_g(1, 2);
        exp_g(1, 1);
        exp_g(1, 0);
        exp_g(1, 3);
        req_v[1] = 8'h0F;
        repeat (5) ack_grant(1);
        req_v[1] = '0;
        chk("t030_queue", 1, gq.size(), 0);

        // Set beats clear on the ack edge; regrant after one bubble.
        do_reset();
        exp_g(0, 2);
        exp_g(0, 2);
        req_v[0] = 8'h04;
        tick();
        req_v[0] = '0;
        tick();
        chk("t022_latency", 0, 32'(val_o[0]), 1);
        chk("t022_idx", 0, 32'(idx_o[0]), 2);
        req_v[0] = 8'h04;
        ack_v[0] = 1'b1;
        tick();
        req_v[0] = '0;
        ack_v[0] = 1'b0;
        chk("t031_bubble", 0, 32'(val_o[0]), 0);
        chk("t031_pend", 0, 32'(pend_o[0]), 32'h04);
        tick();
        chk("t031_regrant", 0, 32'(val_o[0]), 1);
        chk("t031_idx", 0, 32'(idx_o[0]), 2);
        ack_grant(0);
        tick();
        chk("t031_queue", 0, gq.size(), 0);

        // Reset during a grant drops it without an ack.
        do_reset();
        exp_g(0, 2);
        exp_g(0, 2);
        req_v[0] = 8'h06;
        tick();
        req_v[0] = '0;
        tick();
        chk("t032_valid", 0, 32'(val_o[0]), 1);
        chk("t032_pend", 0, 32'(pend_o[0]), 32'h06);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t032_rst_valid", 0, 32'(val_o[0]), 0);
        chk("t032_rst_pend", 0, 32'(pend_o[0]), 0);
        chk("t032_rst_idx", 0, 32'(idx_o[0]), 0);
        req_v[0] = 8'h04;
        tick();
        req_v[0] = '0;
        tick();
        chk("t032_regrant", 0, 32'(val_o[0]), 1);
        chk("t032_idx", 0, 32'(idx_o[0]), 2);
        ack_grant(0);
        tick();
        chk("t032_queue", 0, gq.size(), 0);

        // Everything masked on the 8-wide instance.
        do_reset();
        exp_g(2, 7);
        exp_g(2, 0);
        mask_v[2] = 8'hFF;
        req_v[2]  = 8'h81;
        tick();
        req_v[2] = '0;
        repeat (3) tick();
        chk("t033_valid", 2, 32'(val_o[2]), 0);
        chk("t033_anyp", 2, 32'(anyp_o[2]), 0);
        chk("t033_pend", 2, 32'(pend_o[2]), 32'h81);
        mask_v[2] = '0;
        ack_grant(2);
        ack_grant(2);
        tick();
        chk("t033_pend_end", 2, 32'(pend_o[2]), 0);
        chk("t033_queue", 2, gq.size(), 0);

        // Randomized traffic on all four configurations.
        do_reset();
        directed = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 3) == 0) req_v[d] = '0;
                else req_v[d] = 8'($urandom) & 8'($urandom) & nm(d);
                mask_v[d] = 8'($urandom) & 8'($urandom) & 8'($urandom) & nm(d);
                ack_v[d]  = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst    = 1'b0;
        req_v  = '0;
        mask_v = '0;
        ack_v  = '0;
        tick();
        tick();
        chk("final_queue", 0, gq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_arbiter_n.md
PRIORITY_ARBITER_N -- requirements
Module: priority_arbiter_n

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter N, default 8: number of request lines; legal range 2..32.
REQ-003 Parameter W, default $clog2(N): grant index width; not overridden by users.
REQ-004 Parameter RR_MODE, default 0: 0 = fixed priority, 1 = round-robin.
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port req, input, N bits: request lines; a bit high on an edge latches into pending.
REQ-008 Port mask, input, N bits: a 1 excludes that pending bit from selection; the bit is not cleared.
REQ-009 Port grant_ack, input, 1 bit: consumer accepts the current grant.
REQ-010 Port grant_valid, output, 1 bit: grant_idx is valid and held.
REQ-011 Port grant_idx, output, W bits: index of the granted request.
REQ-012 Port pending, output, N bits: latched request register.
REQ-013 Port any_pending, output, 1 bit: OR of (pending & ~mask).

Function
REQ-014 The pending register SHALL be updated on every edge as pending_next = (pending & ~clr) | req, where clr is the one-hot of grant_idx when an ack is accepted; set SHALL win over clear on the same bit.
REQ-015 The FSM SHALL have two states, IDLE and GRANT; all outputs SHALL be registered.
REQ-016 In IDLE, if (pending & ~mask) != 0, the FSM SHALL load grant_idx with the selected index, set grant_valid = 1 and move to GRANT on the next edge; otherwise it SHALL stay in IDLE.
REQ-017 With RR_MODE = 0, selection SHALL pick the highest set index of (pending & ~mask).
REQ-018 With RR_MODE = 1, the search order after a grant to k SHALL be k-1, k-2, ..., 0, N-1, ..., k (descending with wrap); the pointer k SHALL update only on an accepted ack.
REQ-019 In GRANT, grant_idx and grant_valid SHALL be held stable until grant_ack = 1 is sampled; mask or req changes SHALL NOT revoke or alter the grant.
REQ-020 An accepted ack SHALL, on the same edge, clear pending[grant_idx] (subject to REQ-014), deassert grant_valid and return the FSM to IDLE; a new grant SHALL appear no earlier than the following edge (one-cycle bubble).
REQ-021 grant_ack sampled while grant_valid = 0 SHALL be ignored.
REQ-022 Latency: a req pulse sampled at edge E with the FSM idle and nothing pending SHALL produce grant_valid = 1 after edge E+1.
REQ-023 If all pending bits are masked, the FSM SHALL remain in IDLE, any_pending SHALL be 0, and pending SHALL be retained.
REQ-024 grant_idx SHALL hold its last value while grant_valid = 0.

Reset
REQ-025 When rst = 1 is sampled, the block SHALL clear pending, grant_valid and grant_idx, reset the RR pointer to 0 and enter IDLE, overriding any req or ack on that edge.
REQ-026 Reset asserted while in GRANT SHALL drop the grant without requiring an ack.
REQ-027 With the RR pointer at 0, the first round-robin search order SHALL equal the fixed-priority order (N-1 down to 0).

Verification
REQ-028 N=4, RR_MODE=0, req=4'b0011 for one cycle -> grant idx 1; ack -> grant idx 0; ack -> grant_valid=0, pending=0.
REQ-029 N=4, RR_MODE=0, req=4'b1001 pulse, mask=4'b1000 -> grant idx 0 only; pending[3] stays 1; clearing the mask after the ack -> grant idx 3.
REQ-030 N=4, RR_MODE=1, req held at 4'b1111 with ack every grant -> grant sequence 3,2,1,0,3.
REQ-031 req[2] high on the same edge as the ack of grant idx 2 -> pending[2] remains 1 and idx 2 is granted again after the bubble.
REQ-032 rst=1 asserted while grant_valid=1 with pending=4'b0110 -> next cycle grant_valid=0, pending=0, grant_idx=0; a subsequent req=4'b0100 -> grant idx 2 two edges later.
REQ-033 N=8, mask=8'hFF with req=8'h81 -> no grant, any_pending=0, pending=8'h81; mask set to 0 -> grant idx 7.
